// File: rtl/stage_mem_lsu.sv
// Memory-stage load/store unit: takes one op from EX and runs a single-outstanding
// data-bus transaction, with store lane steering, load extraction and a bus timeout.
module stage_mem_lsu #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        i_clock,
    input  logic        i_reset,
    input  logic        i_req_valid,
    output logic        o_req_ready,
    input  logic        i_req_we,
    input  logic [2:0]  i_req_funct3,
    input  logic [31:0] i_req_addr,
    input  logic [31:0] i_req_wdata,
    input  logic [4:0]  i_req_rd,
    output logic        o_bus_valid,
    input  logic        i_bus_ready,
    output logic        o_bus_we,
    output logic [31:0] o_bus_addr,
    output logic [31:0] o_bus_wdata,
    output logic [3:0]  o_bus_be,
    input  logic        i_bus_rvalid,
    input  logic [31:0] i_bus_rdata,
    output logic        o_reg_we,
    output logic [4:0]  o_reg_wr_addr,
    output logic [31:0] o_reg_wr_data,
    output logic        o_misaligned,
    output logic        o_bus_error
);
    typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;

    state_t      state_q, state_d;
    logic        we_q, we_d;
    logic [2:0]  f3_q, f3_d;
    logic [1:0]  off_q, off_d;
    logic [4:0]  rd_q, rd_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [31:0] bus_addr_q, bus_addr_d;
    logic [31:0] bus_wdata_q, bus_wdata_d;
    logic [3:0]  bus_be_q, bus_be_d;
    logic        reg_we_q, reg_we_d;
    logic [4:0]  wr_addr_q, wr_addr_d;
    logic [31:0] wr_data_q, wr_data_d;
    logic        misal_q, misal_d;
    logic        err_q, err_d;

    logic        accept, illegal, misal, last_cycle;
    logic [3:0]  be_new;
    logic [31:0] wdata_new, ld_data;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;

    assign o_req_ready = (state_q == IDLE) && i_reset;
    assign accept      = i_req_valid && o_req_ready;
    assign illegal     = i_req_we ? (i_req_funct3 >= 3'd3)
                                  : (i_req_funct3 == 3'd3 || i_req_funct3 >= 3'd6);
    assign misal       = (i_req_funct3[1:0] == 2'd1 && i_req_addr[0]) ||
                         (i_req_funct3[1:0] == 2'd2 && i_req_addr[1:0] != 2'd0);
    assign last_cycle  = (cnt_q == 8'(TIMEOUT_CYCLES - 1));

    always_comb begin
        be_new    = 4'b1111;
        wdata_new = i_req_wdata;
        if (i_req_we) begin
            unique case (i_req_funct3[1:0])
                2'd0: begin
                    be_new    = 4'b0001 << i_req_addr[1:0];
                    wdata_new = {4{i_req_wdata[7:0]}};
                end
                2'd1: begin
                    be_new    = i_req_addr[1] ? 4'b1100 : 4'b0011;
                    wdata_new = {2{i_req_wdata[15:0]}};
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        ld_byte = i_bus_rdata[8*off_q +: 8];
        ld_half = i_bus_rdata[16*off_q[1] +: 16];
        unique case (f3_q)
            3'd0:    ld_data = {{24{ld_byte[7]}}, ld_byte};
            3'd1:    ld_data = {{16{ld_half[15]}}, ld_half};
            3'd4:    ld_data = {24'd0, ld_byte};
            3'd5:    ld_data = {16'd0, ld_half};
            default: ld_data = i_bus_rdata;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        we_d        = we_q;
        f3_d        = f3_q;
        off_d       = off_q;
        rd_d        = rd_q;
        cnt_d       = cnt_q;
        bus_addr_d  = bus_addr_q;
        bus_wdata_d = bus_wdata_q;
        bus_be_d    = bus_be_q;
        reg_we_d    = 1'b0;
        wr_addr_d   = wr_addr_q;
        wr_data_d   = wr_data_q;
        misal_d     = 1'b0;
        err_d       = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    if (illegal || misal) begin
                        misal_d = 1'b1;
                    end else begin
                        state_d     = REQ;
                        we_d        = i_req_we;
                        f3_d        = i_req_funct3;
                        off_d       = i_req_addr[1:0];
                        rd_d        = i_req_rd;
                        cnt_d       = 8'd0;
                        bus_addr_d  = {i_req_addr[31:2], 2'b00};
                        bus_wdata_d = wdata_new;
                        bus_be_d    = be_new;
                    end
                end
            end
            REQ, WAIT: begin
                cnt_d = cnt_q + 8'd1;
                // A response completes the op only once the request has been taken,
                // and wins over a timeout landing on the same cycle.
                if (i_bus_rvalid && (state_q == WAIT || i_bus_ready)) begin
                    state_d = IDLE;
                    if (!we_q && rd_q != 5'd0) begin
                        reg_we_d  = 1'b1;
                        wr_addr_d = rd_q;
                        wr_data_d = ld_data;
                    end
                end else if (last_cycle) begin
                    state_d = IDLE;
                    err_d   = 1'b1;
                end else if (state_q == REQ && i_bus_ready) begin
                    state_d = WAIT;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            state_q     <= IDLE;
            we_q        <= 1'b0;
            f3_q        <= 3'd0;
            off_q       <= 2'd0;
            rd_q        <= 5'd0;
            cnt_q       <= 8'd0;
            bus_addr_q  <= 32'd0;
            bus_wdata_q <= 32'd0;
            bus_be_q    <= 4'd0;
            reg_we_q    <= 1'b0;
            wr_addr_q   <= 5'd0;
            wr_data_q   <= 32'd0;
            misal_q     <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            we_q        <= we_d;
            f3_q        <= f3_d;
            off_q       <= off_d;
            rd_q        <= rd_d;
            cnt_q       <= cnt_d;
            bus_addr_q  <= bus_addr_d;
            bus_wdata_q <= bus_wdata_d;
            bus_be_q    <= bus_be_d;
            reg_we_q    <= reg_we_d;
            wr_addr_q   <= wr_addr_d;
            wr_data_q   <= wr_data_d;
            misal_q     <= misal_d;
            err_q       <= err_d;
        end
    end

    assign o_bus_valid   = (state_q == REQ);
    assign o_bus_we      = we_q;
    assign o_bus_addr    = bus_addr_q;
    assign o_bus_wdata   = bus_wdata_q;
    assign o_bus_be      = bus_be_q;
    assign o_reg_we      = reg_we_q;
    assign o_reg_wr_addr = wr_addr_q;
    assign o_reg_wr_data = wr_data_q;
    assign o_misaligned  = misal_q;
    assign o_bus_error   = err_q;
endmodule

// File: tb/tb_stage_mem_lsu.sv
// Bench for stage_mem_lsu: directed and random ops against an arithmetic reference model.
module tb_stage_mem_lsu;
    localparam int T = 4;

    logic        i_clock = 1'b0;
    logic        i_reset = 1'b0;
    logic        i_req_valid = 1'b0, i_req_we = 1'b0;
    logic [2:0]  i_req_funct3 = '0;
    logic [31:0] i_req_addr = '0, i_req_wdata = '0;
    logic [4:0]  i_req_rd = '0;
    logic        i_bus_ready = 1'b0, i_bus_rvalid = 1'b0;
    logic [31:0] i_bus_rdata = '0;
    logic        o_req_ready, o_bus_valid, o_bus_we, o_reg_we, o_misaligned, o_bus_error;
    logic [31:0] o_bus_addr, o_bus_wdata, o_reg_wr_data;
    logic [3:0]  o_bus_be;
    logic [4:0]  o_reg_wr_addr;

    int errors = 0;
    int checks = 0;

    stage_mem_lsu #(.TIMEOUT_CYCLES(T)) dut (
        .i_clock(i_clock), .i_reset(i_reset),
        .i_req_valid(i_req_valid), .o_req_ready(o_req_ready), .i_req_we(i_req_we),
        .i_req_funct3(i_req_funct3), .i_req_addr(i_req_addr), .i_req_wdata(i_req_wdata),
        .i_req_rd(i_req_rd), .o_bus_valid(o_bus_valid), .i_bus_ready(i_bus_ready),
        .o_bus_we(o_bus_we), .o_bus_addr(o_bus_addr), .o_bus_wdata(o_bus_wdata),
        .o_bus_be(o_bus_be), .i_bus_rvalid(i_bus_rvalid), .i_bus_rdata(i_bus_rdata),
        .o_reg_we(o_reg_we), .o_reg_wr_addr(o_reg_wr_addr), .o_reg_wr_data(o_reg_wr_data),
        .o_misaligned(o_misaligned), .o_bus_error(o_bus_error)
    );

    always #5 i_clock = ~i_clock;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    function automatic bit is_bad(input logic we, input logic [2:0] f3, input logic [31:0] a);
        int sz = int'(f3) % 4;
        if (we && f3 >= 3) return 1;
        if (!we && (f3 == 3 || f3 == 6 || f3 == 7)) return 1;
        if (sz == 1 && a % 2 != 0) return 1;
        if (sz == 2 && a % 4 != 0) return 1;
        return 0;
    endfunction

    function automatic logic [31:0] ld_model(input logic [2:0] f3, input logic [31:0] a,
                                             input logic [31:0] rd);
        logic [31:0] v;
        int off = int'(a % 4);
        case (int'(f3) % 4)
            0: begin
                v = (rd >> (off * 8)) & 32'hFF;
                if (f3 == 0 && v >= 128) v = v | 32'hFFFF_FF00;
            end
            1: begin
                v = (rd >> ((off / 2) * 16)) & 32'hFFFF;
                if (f3 == 1 && v >= 32768) v = v | 32'hFFFF_0000;
            end
            default: v = rd;
        endcase
        return v;
    endfunction

    function automatic logic [3:0] be_model(input logic we, input logic [2:0] f3, input logic [31:0] a);
        int off = int'(a % 4);
        if (!we || f3 == 2) return 4'hF;
        if (f3 == 0) return 4'(1 << off);
        return 4'(3 << ((off / 2) * 2));
    endfunction

    function automatic logic [31:0] wd_model(input logic we, input logic [2:0] f3, input logic [31:0] wd);
        if (we && f3 == 0) return (wd & 32'hFF) * 32'h0101_0101;
        if (we && f3 == 1) return (wd & 32'hFFFF) * 32'h0001_0001;
        return wd;
    endfunction

    // d1: bus cycle index at which ready is given; d2: extra cycles until rvalid.
    task automatic do_op(input logic we, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] wd, input logic [4:0] rd,
                         input int d1, input int d2, input logic [31:0] rdata);
        bit wr_exp;
        @(negedge i_clock);
        chk("ready_idle", {31'd0, o_req_ready}, 1);
        i_req_valid = 1; i_req_we = we; i_req_funct3 = f3;
        i_req_addr = a; i_req_wdata = wd; i_req_rd = rd;
        @(negedge i_clock);
        i_req_valid = 0; i_req_addr = $urandom; i_req_wdata = $urandom;
        if (is_bad(we, f3, a)) begin
            chk("misal_pulse", {31'd0, o_misaligned}, 1);
            chk("misal_novalid", {31'd0, o_bus_valid}, 0);
            @(negedge i_clock);
            chk("misal_once", {31'd0, o_misaligned}, 0);
            chk("misal_ready", {31'd0, o_req_ready}, 1);
            chk("misal_novalid2", {31'd0, o_bus_valid}, 0);
            return;
        end
        wr_exp = !we && rd != 0;
        for (int k = 0; k < 64; k++) begin
            chk("valid", {31'd0, o_bus_valid}, (k <= d1) ? 1 : 0);
            if (k <= d1) begin
                chk("addr", o_bus_addr, a & 32'hFFFF_FFFC);
                chk("be", {28'd0, o_bus_be}, {28'd0, be_model(we, f3, a)});
                chk("we", {31'd0, o_bus_we}, {31'd0, we});
                if (we) chk("wdata", o_bus_wdata, wd_model(we, f3, wd));
            end
            chk("no_early_wr", {31'd0, o_reg_we}, 0);
            chk("no_early_err", {31'd0, o_bus_error}, 0);
            i_bus_ready  = (k == d1);
            i_bus_rvalid = (k == d1 + d2) ? 1'b1 : (k < d1) ? 1'($urandom % 2) : 1'b0;
            i_bus_rdata  = (k == d1 + d2) ? rdata : $urandom;
            @(negedge i_clock);
            i_bus_ready = 0; i_bus_rvalid = 0;
            if (k == d1 + d2 && k < T) begin
                chk("reg_we", {31'd0, o_reg_we}, {31'd0, wr_exp});
                if (wr_exp) begin
                    chk("wr_addr", {27'd0, o_reg_wr_addr}, {27'd0, rd});
                    chk("wr_data", o_reg_wr_data, ld_model(f3, a, rdata));
                end
                chk("done_noerr", {31'd0, o_bus_error}, 0);
                chk("done_nomisal", {31'd0, o_misaligned}, 0);
                break;
            end
            if (k == T - 1) begin
                chk("timeout_err", {31'd0, o_bus_error}, 1);
                chk("timeout_nowr", {31'd0, o_reg_we}, 0);
                chk("timeout_novalid", {31'd0, o_bus_valid}, 0);
                // A response arriving after the abort must be dropped.
                i_bus_rvalid = 1; i_bus_rdata = $urandom;
                @(negedge i_clock);
                i_bus_rvalid = 0;
                chk("late_rvalid_nowr", {31'd0, o_reg_we}, 0);
                chk("err_once", {31'd0, o_bus_error}, 0);
                break;
            end
        end
        chk("ready_after", {31'd0, o_req_ready}, 1);
    endtask

    initial begin
        #1;
        chk("rst_ready", {31'd0, o_req_ready}, 0);
        chk("rst_valid", {31'd0, o_bus_valid}, 0);
        chk("rst_outs", {o_reg_we, o_misaligned, o_bus_error, o_bus_we, o_bus_be}, 0);
        chk("rst_addr", o_bus_addr, 0);
        repeat (2) @(negedge i_clock);
        i_reset = 1;

        do_op(0, 3'd2, 32'h100, 0, 5'd5, 0, 0, 32'hDEAD_BEEF);
        do_op(0, 3'd0, 32'h103, 0, 5'd7, 0, 0, 32'h80FF_0000);
        do_op(0, 3'd4, 32'h103, 0, 5'd8, 0, 1, 32'h80FF_0000);
        do_op(0, 3'd1, 32'h102, 0, 5'd9, 1, 0, 32'h80FF_0000);
        do_op(1, 3'd0, 32'h201, 32'h1234_5678, 5'd3, 1, 1, 32'h0);
        do_op(1, 3'd1, 32'h202, 32'h1234_5678, 5'd3, 0, 0, 32'h0);
        do_op(0, 3'd2, 32'h102, 0, 5'd4, 0, 0, 32'h0);
        do_op(0, 3'd2, 32'h300, 0, 5'd6, 3, 9, 32'h0);
        do_op(0, 3'd2, 32'h304, 0, 5'd6, 2, 1, 32'h1357_9BDF);
        do_op(0, 3'd2, 32'h308, 0, 5'd6, 6, 0, 32'h0);

        // Reset while waiting for the response.
        @(negedge i_clock);
        i_req_valid = 1; i_req_we = 0; i_req_funct3 = 3'd2; i_req_addr = 32'h400; i_req_rd = 5'd10;
        @(negedge i_clock);
        i_req_valid = 0; i_bus_ready = 1;
        @(negedge i_clock);
        i_bus_ready = 0;
        chk("wait_novalid", {31'd0, o_bus_valid}, 0);
        i_reset = 0;
        #1;
        chk("mid_rst_ready", {31'd0, o_req_ready}, 0);
        chk("mid_rst_outs", {o_bus_valid, o_reg_we, o_misaligned, o_bus_error, o_bus_we, o_bus_be}, 0);
        chk("mid_rst_addr", o_bus_addr, 0);
        chk("mid_rst_wr", {o_reg_wr_addr, 27'd0} | o_reg_wr_data, 0);
        @(negedge i_clock);
        i_reset = 1; i_bus_rvalid = 1; i_bus_rdata = 32'hAAAA_5555;
        @(negedge i_clock);
        i_bus_rvalid = 0;
        chk("post_rst_nowr", {31'd0, o_reg_we}, 0);
        chk("post_rst_novalid", {31'd0, o_bus_valid}, 0);
        do_op(0, 3'd2, 32'h500, 0, 5'd0, 0, 0, 32'hFFFF_FFFF);

        for (int n = 0; n < 60; n++) begin
            logic [31:0] a = $urandom;
            do_op(1'($urandom % 2), 3'($urandom % 8), a, $urandom, 5'($urandom),
                  int'($urandom_range(0, 4)), int'($urandom_range(0, 3)), $urandom);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end
endmodule
